// File: rtl/rr_arbiter_fsm.sv
// Round-robin arbiter with a three-state IDLE/GRANT/RELEASE controller and Moore outputs.
// Optional grant-length limit is enabled by defining ARB_TIMEOUT_EN.
module rr_arbiter_fsm #(
   parameter int N_REQ          = 4,
   parameter int ID_W           = 2,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic [N_REQ-1:0] req,
   input  logic             done,
   output logic [N_REQ-1:0] gnt,
   output logic [ID_W-1:0]  gnt_id,
   output logic             busy,
   output logic             timeout
);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_GRANT   = 2'd1;
   localparam logic [1:0] S_RELEASE = 2'd2;

   localparam logic [ID_W-1:0] LAST_RST = ID_W'(N_REQ - 1);

   if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
      $error("rr_arbiter_fsm: N_REQ must be in 2..8");
   end
   if (ID_W != $clog2(N_REQ)) begin : g_bad_id_w
      $error("rr_arbiter_fsm: ID_W must equal clog2(N_REQ)");
   end
   if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
      $error("rr_arbiter_fsm: TIMEOUT_CYCLES must be in 2..255");
   end

   logic [1:0]      state_q, state_d;
   logic [ID_W-1:0] owner_q, owner_d;
   logic [ID_W-1:0] last_q,  last_d;
   logic [ID_W-1:0] winner;

   // Search starts one past the previous owner, so the last owner has lowest priority.
   always_comb begin
      // NOTE: every combinationally assigned signal gets a default first, so no path can infer a latch.
      winner = last_q;
      for (int i = N_REQ; i >= 1; i--) begin
         int idx;
         idx = (int'(last_q) + i) % N_REQ;
         if (req[idx]) winner = ID_W'(idx);
      end
   end

`ifdef ARB_TIMEOUT_EN
   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

   logic [7:0] cnt_q, cnt_d;
   logic       to_q,  to_d;
`endif

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
`ifdef ARB_TIMEOUT_EN
      cnt_d   = cnt_q;
      to_d    = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            if (|req) begin
               state_d = S_GRANT;
               owner_d = winner;
`ifdef ARB_TIMEOUT_EN
               cnt_d   = '0;
`endif
            end
         end
         S_GRANT: begin
            if (done) begin
               state_d = S_RELEASE;
               last_d  = owner_q;
            end
`ifdef ARB_TIMEOUT_EN
            // done on the final counted cycle wins over the forced release.
            else if (cnt_q == CNT_LAST) begin
               state_d = S_RELEASE;
               last_d  = owner_q;
               to_d    = 1'b1;
            end else begin
               cnt_d   = cnt_q + 8'd1;
            end
`endif
         end
         S_RELEASE: state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q <= S_IDLE;
         owner_q <= '0;
         last_q  <= LAST_RST;
`ifdef ARB_TIMEOUT_EN
         cnt_q   <= '0;
         to_q    <= 1'b0;
`endif
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
`ifdef ARB_TIMEOUT_EN
         cnt_q   <= cnt_d;
         to_q    <= to_d;
`endif
      end
   end

   always_comb begin
      gnt = '0;
      if (state_q == S_GRANT) gnt[owner_q] = 1'b1;
   end

   assign gnt_id = owner_q;
   assign busy   = (state_q != S_IDLE);

`ifdef ARB_TIMEOUT_EN
   assign timeout = to_q;
`else
   assign timeout = 1'b0;
`endif

   a_gnt_onehot0 : assert property (@(posedge clk) disable iff (!n_rst) $onehot0(gnt));
   a_release_1cy : assert property (@(posedge clk) disable iff (!n_rst)
                                    (state_q == S_RELEASE) |=> (state_q == S_IDLE));
   a_state_legal : assert property (@(posedge clk) disable iff (!n_rst) (state_q != 2'd3));

endmodule

// File: tb/tb_rr_arbiter_fsm.sv
// Directed bench for rr_arbiter_fsm: a vector table for arbitration order plus
// hand-written sequences for hold, reset abort and (with ARB_TIMEOUT_EN) forced release.
module tb_rr_arbiter_fsm;

   logic       clk = 1'b0;
   logic       n_rst;
   logic [3:0] req;
   logic       done;
   logic [3:0] gnt;
   logic [1:0] gnt_id;
   logic       busy;
   logic       timeout;

   int checks = 0;
   int errors = 0;

   rr_arbiter_fsm #(.N_REQ(4), .ID_W(2), .TIMEOUT_CYCLES(16)) dut (
      .clk     (clk),
      .n_rst   (n_rst),
      .req     (req),
      .done    (done),
      .gnt     (gnt),
      .gnt_id  (gnt_id),
      .busy    (busy),
      .timeout (timeout)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] req;
      logic       done;
      logic [3:0] gnt;
      logic [1:0] id;
      logic       busy;
   } vec_t;

   localparam int NV = 31;
   vec_t vecs [NV];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // inputs, then the outputs expected just after the edge that samples them
      vecs[0]  = '{4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0};
      vecs[1]  = '{4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0};
      vecs[2]  = '{4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1};
      vecs[3]  = '{4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1};
      vecs[4]  = '{4'b0001, 1'b1, 4'b0000, 2'd0, 1'b1};
      vecs[5]  = '{4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0};
      vecs[6]  = '{4'b1111, 1'b0, 4'b0010, 2'd1, 1'b1};
      vecs[7]  = '{4'b1111, 1'b1, 4'b0000, 2'd1, 1'b1};
      vecs[8]  = '{4'b1111, 1'b0, 4'b0000, 2'd1, 1'b0};
      vecs[9]  = '{4'b1111, 1'b0, 4'b0100, 2'd2, 1'b1};
      vecs[10] = '{4'b1111, 1'b1, 4'b0000, 2'd2, 1'b1};
      vecs[11] = '{4'b1111, 1'b0, 4'b0000, 2'd2, 1'b0};
      vecs[12] = '{4'b1111, 1'b0, 4'b1000, 2'd3, 1'b1};
      vecs[13] = '{4'b1111, 1'b1, 4'b0000, 2'd3, 1'b1};
      vecs[14] = '{4'b1111, 1'b0, 4'b0000, 2'd3, 1'b0};
      vecs[15] = '{4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1};
      vecs[16] = '{4'b1111, 1'b1, 4'b0000, 2'd0, 1'b1};
      vecs[17] = '{4'b1111, 1'b0, 4'b0000, 2'd0, 1'b0};
      vecs[18] = '{4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1};
      vecs[19] = '{4'b0000, 1'b0, 4'b0010, 2'd1, 1'b1};
      vecs[20] = '{4'b1011, 1'b1, 4'b0000, 2'd1, 1'b1};
      vecs[21] = '{4'b1011, 1'b0, 4'b0000, 2'd1, 1'b0};
      vecs[22] = '{4'b1011, 1'b0, 4'b1000, 2'd3, 1'b1};
      vecs[23] = '{4'b1011, 1'b1, 4'b0000, 2'd3, 1'b1};
      vecs[24] = '{4'b1011, 1'b0, 4'b0000, 2'd3, 1'b0};
      vecs[25] = '{4'b1011, 1'b0, 4'b0001, 2'd0, 1'b1};
      vecs[26] = '{4'b1011, 1'b1, 4'b0000, 2'd0, 1'b1};
      vecs[27] = '{4'b1011, 1'b0, 4'b0000, 2'd0, 1'b0};
      vecs[28] = '{4'b1011, 1'b0, 4'b0010, 2'd1, 1'b1};
      vecs[29] = '{4'b1011, 1'b1, 4'b0000, 2'd1, 1'b1};
      vecs[30] = '{4'b0000, 1'b0, 4'b0000, 2'd1, 1'b0};

      n_rst = 1'b0;
      req   = '0;
      done  = 1'b0;
      #3;
      check("rst_gnt",     32'(gnt),     32'h0);
      check("rst_gnt_id",  32'(gnt_id),  32'h0);
      check("rst_busy",    32'(busy),    32'h0);
      check("rst_timeout", 32'(timeout), 32'h0);
      #9 n_rst = 1'b1;

      for (int v = 0; v < NV; v++) begin
         req  = vecs[v].req;
         done = vecs[v].done;
         tick();
         check($sformatf("v%0d_gnt", v),     32'(gnt),     32'(vecs[v].gnt));
         check($sformatf("v%0d_gnt_id", v),  32'(gnt_id),  32'(vecs[v].id));
         check($sformatf("v%0d_busy", v),    32'(busy),    32'(vecs[v].busy));
         check($sformatf("v%0d_timeout", v), 32'(timeout), 32'h0);
      end
      done = 1'b0;

`ifdef ARB_TIMEOUT_EN
      begin
         int n_high;
         req = 4'b0010;
         tick();
         check("to_first_gnt", 32'(gnt), 32'h2);
         n_high = 1;
         for (int c = 0; c < 40; c++) begin
            tick();
            if (gnt == 4'b0010) n_high++;
            else break;
         end
         check("to_gnt_len",   32'(n_high),  32'd16);
         check("to_pulse",     32'(timeout), 32'h1);
         check("to_rel_busy",  32'(busy),    32'h1);
         check("to_rel_gnt",   32'(gnt),     32'h0);
         req = 4'b1111;
         tick();
         check("to_pulse_end", 32'(timeout), 32'h0);
         check("to_idle_busy", 32'(busy),    32'h0);
         tick();
         check("to_next_gnt",  32'(gnt),     32'h4);
         check("to_next_id",   32'(gnt_id),  32'h2);
         for (int c = 0; c < 15; c++) tick();
         check("to_last_cycle_gnt", 32'(gnt), 32'h4);
         done = 1'b1;
         tick();
         done = 1'b0;
         check("to_done_wins_to",   32'(timeout), 32'h0);
         check("to_done_wins_gnt",  32'(gnt),     32'h0);
         req = 4'b0000;
         tick();
         check("to_done_wins_idle", 32'(busy),    32'h0);
      end
`else
      req = 4'b0100;
      tick();
      check("hold_first_gnt", 32'(gnt), 32'h4);
      req = 4'b0000;
      for (int c = 0; c < 100; c++) begin
         tick();
         check($sformatf("hold_c%0d_gnt", c), 32'(gnt), 32'h4);
         check($sformatf("hold_c%0d_to", c),  32'(timeout), 32'h0);
      end
      done = 1'b1;
      tick();
      done = 1'b0;
      check("hold_rel_gnt",  32'(gnt),  32'h0);
      check("hold_rel_busy", 32'(busy), 32'h1);
      tick();
      check("hold_idle_busy", 32'(busy), 32'h0);
      done = 1'b1;
      tick();
      check("idle_done_busy", 32'(busy),   32'h0);
      check("idle_done_id",   32'(gnt_id), 32'h2);
      tick();
      done = 1'b0;
      check("idle_done_busy2", 32'(busy), 32'h0);
`endif

      // Owner 2 was last, so a lone req on 1 wins; then reset aborts it between edges.
      req = 4'b0010;
      tick();
      check("pre_rst_gnt", 32'(gnt), 32'h2);
      #3 n_rst = 1'b0;
      #1;
      check("async_rst_gnt",  32'(gnt),     32'h0);
      check("async_rst_busy", 32'(busy),    32'h0);
      check("async_rst_id",   32'(gnt_id),  32'h0);
      check("async_rst_to",   32'(timeout), 32'h0);
      req = 4'b1111;
      #2 n_rst = 1'b1;
      tick();
      check("post_rst_gnt", 32'(gnt),    32'h1);
      check("post_rst_id",  32'(gnt_id), 32'h0);
      check("post_rst_busy", 32'(busy),  32'h1);
      req  = 4'b0000;
      done = 1'b1;
      tick();
      done = 1'b0;
      check("post_rst_rel", 32'(gnt), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
